// File: rtl/reset_sequencer.sv
// Per-domain reset generator. It filters PLL lock, holds every reset for a fixed time,
// and then releases the channels one at a time. Define RESET_SEQ_LOCK_LOSS_CNT_EN to add the lock_loss_count output.
module reset_sequencer #(
    parameter int NUM_CH      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILTER = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              rst_condition,
    input  logic              pll_locked,
    input  logic              sw_reset_req,
    output logic [NUM_CH-1:0] rst_n_out,
    output logic              seq_done,
    output logic [1:0]        state
`ifdef RESET_SEQ_LOCK_LOSS_CNT_EN
    ,
    output logic [7:0]        lock_loss_count
`endif
);

    localparam int LOCK_W = $clog2(LOCK_FILTER) + 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
    localparam int GAP_W  = $clog2(GAP_CYCLES) + 1;
    localparam int IDX_W  = $clog2(NUM_CH) + 1;

    localparam logic [NUM_CH-1:0] ONE      = NUM_CH'(1);
    localparam logic [NUM_CH-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t cur_state, next_state;

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   lock_sync;

    logic [LOCK_W-1:0] lock_cnt, lock_cnt_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
    logic [IDX_W-1:0]  rel_idx, rel_idx_nxt;
    logic [NUM_CH-1:0] rst_n_nxt;
    logic              seq_done_nxt;

    // pll_locked is asynchronous to clk, so it passes through a plain flop chain first.
    always_ff @(posedge clk or posedge rst_condition) begin
        if (rst_condition) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign lock_sync = sync_ff[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst_condition) begin
        if (rst_condition) begin
            cur_state <= WAIT_LOCK;
            lock_cnt  <= '0;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            rel_idx   <= '0;
            rst_n_out <= '0;
            seq_done  <= 1'b0;
        end else begin
            cur_state <= next_state;
            lock_cnt  <= lock_cnt_nxt;
            hold_cnt  <= hold_cnt_nxt;
            gap_cnt   <= gap_cnt_nxt;
            rel_idx   <= rel_idx_nxt;
            rst_n_out <= rst_n_nxt;
            seq_done  <= seq_done_nxt;
        end
    end

    assign state = cur_state;

    // Lock loss outranks a software request, and both outrank normal sequencing.
    always_comb begin
        next_state   = cur_state;
        lock_cnt_nxt = lock_cnt;
        hold_cnt_nxt = hold_cnt;
        gap_cnt_nxt  = gap_cnt;
        rel_idx_nxt  = rel_idx;
        rst_n_nxt    = rst_n_out;
        seq_done_nxt = seq_done;

        if (cur_state == WAIT_LOCK) begin
            rst_n_nxt    = '0;
            seq_done_nxt = 1'b0;
            hold_cnt_nxt = '0;
            gap_cnt_nxt  = '0;
            rel_idx_nxt  = '0;
            if (!lock_sync) begin
                lock_cnt_nxt = '0;
            end else if (lock_cnt == LOCK_W'(LOCK_FILTER - 1)) begin
                next_state   = HOLD;
                lock_cnt_nxt = '0;
            end else begin
                lock_cnt_nxt = lock_cnt + 1'b1;
            end
        end else if (!lock_sync) begin
            next_state   = WAIT_LOCK;
            lock_cnt_nxt = '0;
            hold_cnt_nxt = '0;
            gap_cnt_nxt  = '0;
            rel_idx_nxt  = '0;
            rst_n_nxt    = '0;
            seq_done_nxt = 1'b0;
        end else if (sw_reset_req && (cur_state == RELEASE || cur_state == RUN)) begin
            next_state   = HOLD;
            hold_cnt_nxt = '0;
            gap_cnt_nxt  = '0;
            rel_idx_nxt  = '0;
            rst_n_nxt    = '0;
            seq_done_nxt = 1'b0;
        end else begin
            case (cur_state)
                HOLD: begin
                    rst_n_nxt    = '0;
                    seq_done_nxt = 1'b0;
                    if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                        hold_cnt_nxt = '0;
                        gap_cnt_nxt  = '0;
                        rst_n_nxt    = ONE;
                        if (NUM_CH == 1) begin
                            next_state   = RUN;
                            seq_done_nxt = 1'b1;
                        end else begin
                            next_state  = RELEASE;
                            rel_idx_nxt = IDX_W'(1);
                        end
                    end else begin
                        hold_cnt_nxt = hold_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        gap_cnt_nxt = '0;
                        rst_n_nxt   = rst_n_out | (ONE << rel_idx);
                        if (rel_idx == IDX_W'(NUM_CH - 1)) begin
                            next_state   = RUN;
                            seq_done_nxt = 1'b1;
                        end else begin
                            rel_idx_nxt = rel_idx + 1'b1;
                        end
                    end else begin
                        gap_cnt_nxt = gap_cnt + 1'b1;
                    end
                end
                RUN: begin
                    rst_n_nxt    = ALL_ONES;
                    seq_done_nxt = 1'b1;
                end
                default: begin
                    next_state = WAIT_LOCK;
                end
            endcase
        end
    end

`ifdef RESET_SEQ_LOCK_LOSS_CNT_EN
    logic lock_loss;

    assign lock_loss = (cur_state != WAIT_LOCK) && !lock_sync;

    always_ff @(posedge clk or posedge rst_condition) begin
        if (rst_condition) begin
            lock_loss_count <= '0;
        end else if (lock_loss && lock_loss_count != 8'hFF) begin
            lock_loss_count <= lock_loss_count + 8'd1;
        end
    end
`endif

endmodule
